// File: rtl/riscv_pkg.sv
// Shared RV32I constants and types used by the register file and its read ports.
package riscv_pkg;
  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  typedef logic [XLEN-1:0]   xlen_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

  localparam xlen_t REG_ZERO = '0;
endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: array mux with x0/out-of-range zeroing.
// Optional same-cycle write-through when FWD_BYPASS_EN is defined.
module reg_file_rd_port
  import riscv_pkg::*;
#(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int NUM_REGS = riscv_pkg::NUM_REGS,
  parameter int ADDR_W   = riscv_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [XLEN-1:0]   regs_i [NUM_REGS],
  input  logic              byp_en_i,
  input  logic [ADDR_W-1:0] byp_addr_i,
  input  logic [XLEN-1:0]   byp_data_i,
  output logic [XLEN-1:0]   rd_data_o
);

  logic in_range;

  generate
    if (NUM_REGS >= (1 << ADDR_W)) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_part
      localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_REGS);
      assign in_range = ({1'b0, rs_addr_i} < LIMIT);
    end
  endgenerate

`ifdef FWD_BYPASS_EN
  always_comb begin
    rd_data_o = '0;
    if (rs_addr_i != '0 && in_range) rd_data_o = regs_i[rs_addr_i];
    // byp_en_i already excludes x0 and out-of-range targets
    if (byp_en_i && byp_addr_i == rs_addr_i) rd_data_o = byp_data_i;
  end
`else
  logic unused_byp;
  assign unused_byp = ^{byp_en_i, byp_addr_i, byp_data_i};

  always_comb begin
    rd_data_o = '0;
    if (rs_addr_i != '0 && in_range) rd_data_o = regs_i[rs_addr_i];
  end
`endif

endmodule

// File: rtl/reg_file.sv
// RV32I integer register file: two async read ports, one handshaked write port,
// x0 hard-wired to zero, saturating commit counter. Build option: FWD_BYPASS_EN.
module reg_file
  import riscv_pkg::*;
#(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int NUM_REGS = riscv_pkg::NUM_REGS,
  parameter int ADDR_W   = riscv_pkg::ADDR_W,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   REG_1,
  output logic [XLEN-1:0]   REG_2,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]   rd_data,
  output logic [CNT_W-1:0]  wr_count
);

  logic [XLEN-1:0]  regs_q [NUM_REGS];
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_in_range;
  logic             wr_en;

  generate
    if (NUM_REGS >= (1 << ADDR_W)) begin : g_full
      assign rd_in_range = 1'b1;
    end else begin : g_part
      localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_REGS);
      assign rd_in_range = ({1'b0, rd_addr} < LIMIT);
    end
  endgenerate

  // Only handshakes that actually change architectural state count as commits
  assign wr_en = wr_valid && ready_q && (rd_addr != '0) && rd_in_range;

  always_comb begin
    ready_d = 1'b1;
    cnt_d   = cnt_q;
    if (wr_en && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[rd_addr] <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wr_ready = ready_q;
  assign wr_count = cnt_q;

  reg_file_rd_port #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_rd1 (
    .rs_addr_i  (rs1_addr),
    .regs_i     (regs_q),
    .byp_en_i   (wr_en),
    .byp_addr_i (rd_addr),
    .byp_data_i (rd_data),
    .rd_data_o  (REG_1)
  );

  reg_file_rd_port #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_rd2 (
    .rs_addr_i  (rs2_addr),
    .regs_i     (regs_q),
    .byp_en_i   (wr_en),
    .byp_addr_i (rd_addr),
    .byp_data_i (rd_data),
    .rd_data_o  (REG_2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: a 16-bit-counter instance and a 2-bit-counter
// instance share all inputs; expectations come from a small reference model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rd_data;
  logic        wr_valid;

  logic [31:0] REG_1, REG_2, REG_1_s, REG_2_s;
  logic        wr_ready, wr_ready_s;
  logic [15:0] wr_count;
  logic [1:0]  wr_count_s;

`ifdef FWD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  reg_file #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .REG_1(REG_1), .REG_2(REG_2), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_count(wr_count)
  );

  reg_file #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .REG_1(REG_1_s), .REG_2(REG_2_s), .wr_valid(wr_valid), .wr_ready(wr_ready_s),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_count(wr_count_s)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;

  logic [31:0] mregs [32];
  int          mcnt;
  bit          mready;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       obs = REG_1;
        1:       obs = REG_2;
        2:       obs = {16'b0, wr_count};
        3:       obs = {31'b0, wr_ready};
        4:       obs = {30'b0, wr_count_s};
        5:       obs = REG_1_s;
        6:       obs = REG_2_s;
        default: obs = {31'b0, wr_ready_s};
      endcase
      check_val(e.tag, obs, e.val);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] rs);
    if (BYP && wr_valid && mready && rd_addr != 5'd0 && rd_addr == rs) return rd_data;
    return mregs[rs];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mcnt   = 0;
    mready = 1'b0;
  endtask

  task automatic expect_all(input string tag);
    expect_out({tag, "_reg1"}, 0, exp_read(rs1_addr));
    expect_out({tag, "_reg2"}, 1, exp_read(rs2_addr));
    expect_out({tag, "_cnt"}, 2, 32'(mcnt));
    expect_out({tag, "_rdy"}, 3, {31'b0, mready});
    expect_out({tag, "_cnt_sat"}, 4, (mcnt > 3) ? 32'd3 : 32'(mcnt));
    expect_out({tag, "_s_reg1"}, 5, exp_read(rs1_addr));
    expect_out({tag, "_s_reg2"}, 6, exp_read(rs2_addr));
    expect_out({tag, "_s_rdy"}, 7, {31'b0, mready});
  endtask

  task automatic tick();
    @(posedge clk);
    if (wr_valid && mready && rd_addr != 5'd0) begin
      mregs[rd_addr] = rd_data;
      mcnt++;
    end
    mready = 1'b1;
    #1;
  endtask

  task automatic write(input logic [4:0] rd, input logic [31:0] d);
    wr_valid = 1'b1;
    rd_addr  = rd;
    rd_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; rd_addr = 5'd0; rd_data = 32'd0;
    rs1_addr = 5'd5; rs2_addr = 5'd31;
    model_reset();
    #2;
    expect_all("rst_init");
    drain();

    // Handshake ignored while wr_ready is still low after release
    #5 rst_n = 1'b1;
    wr_valid = 1'b1; rd_addr = 5'd9; rd_data = 32'hA; rs1_addr = 5'd9;
    #1;
    expect_all("t5_pre");
    drain();
    tick();
    wr_valid = 1'b0;
    #1;
    expect_all("t5_post");
    expect_out("t5_x9", 0, 32'd0);
    expect_out("t5_cnt", 2, 32'd0);
    expect_out("t5_rdy", 3, 32'd1);
    drain();

    write(5'd7, 32'hDEADBEEF);
    rs1_addr = 5'd7; rs2_addr = 5'd0;
    #1;
    expect_all("t2");
    expect_out("t2_x7", 0, 32'hDEADBEEF);
    expect_out("t2_x0", 1, 32'd0);
    expect_out("t2_cnt1", 2, 32'd1);
    drain();

    write(5'd0, 32'hFFFFFFFF);
    rs1_addr = 5'd0;
    #1;
    expect_all("t3");
    expect_out("t3_x0", 0, 32'd0);
    expect_out("t3_cnt", 2, 32'd1);
    drain();

    write(5'd3, 32'h1);
    wr_valid = 1'b1; rd_addr = 5'd3; rd_data = 32'h12345678;
    rs1_addr = 5'd3; rs2_addr = 5'd3;
    #1;
    expect_all("t4_same");
    expect_out("t4_same_r1", 0, BYP ? 32'h12345678 : 32'h1);
    expect_out("t4_same_r2", 1, BYP ? 32'h12345678 : 32'h1);
    drain();
    tick();
    wr_valid = 1'b0;
    #1;
    expect_all("t4_next");
    expect_out("t4_next_r1", 0, 32'h12345678);
    expect_out("t4_next_r2", 1, 32'h12345678);
    drain();

    write(5'd5, 32'h55555555);
    write(5'd31, 32'h31313131);
    rs1_addr = 5'd5; rs2_addr = 5'd31;
    #1;
    expect_all("hi_regs");
    drain();

    for (int i = 0; i < 24; i++) begin
      rd_addr  = 5'($urandom_range(0, 31));
      rd_data  = $urandom;
      rs1_addr = (i % 3 == 0) ? rd_addr : 5'($urandom_range(0, 31));
      rs2_addr = (i % 4 == 0) ? rd_addr : 5'($urandom_range(0, 31));
      wr_valid = ($urandom_range(0, 3) != 0);
      #1;
      expect_all("rnd_cyc");
      drain();
      tick();
      wr_valid = 1'b0;
      #1;
      expect_all("rnd_post");
      drain();
    end

    // Asynchronous reset mid-run, with a write pending, no clock edge needed
    rs1_addr = 5'd5; rs2_addr = 5'd31;
    wr_valid = 1'b1; rd_addr = 5'd12; rd_data = 32'hCAFE0001;
    rst_n = 1'b0;
    model_reset();
    #1;
    expect_all("t1_rst");
    expect_out("t1_reg1", 0, 32'd0);
    expect_out("t1_reg2", 1, 32'd0);
    expect_out("t1_cnt", 2, 32'd0);
    expect_out("t1_rdy", 3, 32'd0);
    drain();
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rs1_addr = 5'd12;
    expect_all("t1_hold");
    drain();
    rst_n = 1'b1;
    tick();
    #1;
    expect_all("t1_rel");
    expect_out("t1_x12_lost", 0, 32'd0);
    drain();

    for (int i = 1; i <= 5; i++) write(5'(i + 10), 32'(i * 32'h1111));
    rs1_addr = 5'd15; rs2_addr = 5'd11;
    #1;
    expect_all("t6");
    expect_out("t6_cnt16", 2, 32'd5);
    expect_out("t6_cnt_sat", 4, 32'd3);
    expect_out("t6_x15", 0, 32'h5555);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
